// File: rtl/uart_pkg.sv
// Shared definitions for the debug UART transmit path: byte width,
// serializer bit-timer limit and the buffer FSM state encodings.
package uart_pkg;

    localparam int BYTE_W = 8;

    // 100 MHz / 115200 baud, shared with the uart_tx serializer bit timer
    localparam int BIT_TMR_MAX = 868;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_SEND    = 2'b01,
        ST_RELEASE = 2'b10
    } tx_state_t;

endpackage

// File: rtl/uart_tx_fifo.sv
// Parameterised synchronous byte FIFO with registered occupancy, full and
// empty flags; pointers wrap modulo 2^DEPTH_LOG2.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [BYTE_W-1:0]     push_data,
    input  logic                  pop,
    output logic [BYTE_W-1:0]     head,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  full,
    output logic                  empty
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] DEPTH_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};

    logic [BYTE_W-1:0]     mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic                  push_ok;
    logic                  pop_ok;
    logic [DEPTH_LOG2:0]   count_next;

    // Qualify requests against the pre-edge flags and form the next occupancy
    always_comb begin
        push_ok    = push & ~full;
        pop_ok     = pop & ~empty;
        count_next = count;
        case ({push_ok, pop_ok})
            2'b10:   count_next = count + {{DEPTH_LOG2{1'b0}}, 1'b1};
            2'b01:   count_next = count - {{DEPTH_LOG2{1'b0}}, 1'b1};
            default: count_next = count;
        endcase
    end

    // Storage array; contents need no reset since count gates every read
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers, occupancy and flags, all registered
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= {DEPTH_LOG2{1'b0}};
            rd_ptr <= {DEPTH_LOG2{1'b0}};
            count  <= {(DEPTH_LOG2 + 1){1'b0}};
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + {{(DEPTH_LOG2 - 1){1'b0}}, 1'b1};
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + {{(DEPTH_LOG2 - 1){1'b0}}, 1'b1};
            end
            count <= count_next;
            full  <= (count_next == DEPTH_CNT);
            empty <= (count_next == {(DEPTH_LOG2 + 1){1'b0}});
        end
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/uart_tx_buffer.sv
// Byte-queueing front end for the debug UART: FIFO plus send/done handshake FSM.
// Define UART_TXBUF_OVF_EN to build the sticky overflow flag; otherwise it reads 0.
module uart_tx_buffer
    import uart_pkg::*;
#(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [BYTE_W-1:0]     wr_data,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  busy,
    output logic                  overflow,
    output logic                  tx_send,
    output logic [BYTE_W-1:0]     tx_data,
    input  logic                  tx_done
);

    tx_state_t         state;
    logic              pop;
    logic [BYTE_W-1:0] head;

    uart_tx_fifo #(
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (wr_en),
        .push_data (wr_data),
        .pop       (pop),
        .head      (head),
        .count     (count),
        .full      (full),
        .empty     (empty)
    );

    // Pop on the same edge that loads the holding register and raises tx_send
    always_comb begin
        pop = 1'b0;
        if ((state == ST_IDLE) && !empty) begin
            pop = 1'b1;
        end else begin
            pop = 1'b0;
        end
    end

    // Handshake FSM; tx_data is loaded only on IDLE->SEND so it stays stable all frame
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            tx_send <= 1'b0;
            tx_data <= {BYTE_W{1'b0}};
        end else begin
            case (state)
                ST_IDLE: begin
                    if (!empty) begin
                        tx_data <= head;
                        tx_send <= 1'b1;
                        state   <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (tx_done) begin
                        tx_send <= 1'b0;
                        state   <= ST_RELEASE;
                    end
                end
                ST_RELEASE: begin
                    if (!tx_done) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    tx_send <= 1'b0;
                    state   <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy = !empty || (state != ST_IDLE);

`ifdef UART_TXBUF_OVF_EN
    logic overflow_r;

    // Sticky record of any dropped push, cleared only by reset
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow_r <= 1'b0;
        end else if (wr_en && full) begin
            overflow_r <= 1'b1;
        end
    end

    assign overflow = overflow_r;
`else
    assign overflow = 1'b0;
`endif

endmodule

// File: doc/uart_tx_buffer.md
# uart_tx_buffer

Byte-queueing front end for the NAND debug UART transmitter. It accepts bytes from the controller/status logic in single-cycle writes and stores them in a synchronous FIFO. It then drains them one at a time into the `uart_tx` serializer using that block's level `send`/`done` handshake. Writers never stall on the 115200-baud link unless the FIFO fills.

## Interface
Parameters:
- `DEPTH_LOG2`, default 4: FIFO depth is 2^DEPTH_LOG2 entries (16 by default).

Ports:
- `clk`  in  1: single clock domain, shared with `uart_tx`.
- `rst`  in  1: synchronous, active-high reset.
- `wr_en`  in  1: push request; sampled on `clk` rising edge.
- `wr_data`  in  8: byte to push.
- `full`  out  1: FIFO holds 2^DEPTH_LOG2 bytes.
- `empty`  out  1: FIFO holds 0 bytes.
- `count`  out  DEPTH_LOG2+1: current FIFO occupancy.
- `busy`  out  1: high when `empty` is low or the FSM is not in IDLE.
- `overflow`  out  1: sticky flag, set when a push is dropped.
- `tx_send`  out  1: drives `uart_tx.send`.
- `tx_data`  out  8: drives `uart_tx.data_tx`; registered holding byte.
- `tx_done`  in  1: from `uart_tx.done`.

## Operation
- FIFO: registered memory with DEPTH_LOG2-bit read and write pointers that wrap modulo depth. `count` is the occupancy.
- Push: when `wr_en` is high and `full` is low, `wr_data` is written at the write pointer, and the pointer and `count` increment.
- Push while full: the byte is dropped, with no pointer change. `overflow` sets (see Configuration).
- `full` is evaluated before the edge. A push while full is rejected even if a pop occurs in the same cycle.
- A simultaneous accepted push and pop leaves `count` unchanged.
- FSM states: IDLE, SEND, RELEASE.
  - IDLE: if `count != 0`, pop the head into `tx_data`, set `tx_send=1`, go to SEND. Otherwise stay in IDLE.
  - SEND: hold `tx_send=1` and hold `tx_data` stable. When `tx_done==1`, set `tx_send=0` and go to RELEASE.
  - RELEASE: hold `tx_data`. When `tx_done==0`, go to IDLE.
- `tx_data` changes only at the IDLE→SEND edge. `uart_tx` samples `data_tx` combinationally across the whole frame, so `tx_data` must not change earlier.
- Unreachable state encodings go to IDLE with `tx_send=0`.

## Timing
- Reset values:
  - `tx_send=0`, `tx_data=8'h00`, `overflow=0`.
  - `count=0`, `empty=1`, `full=0`, `busy=0`.
  - Pointers are 0 and the FSM is in IDLE.
- Reset mid-frame: everything above applies on the next edge and queued bytes are discarded. `uart_tx` shares `rst`, so the line returns idle.
- Latency, write into an empty idle buffer: `wr_en` sampled at edge N → `count=1` after N → `tx_send=1` and `tx_data` valid after edge N+1.
- Pop timing: the pop occurs on the same edge that raises `tx_send`. `count` decrements at that edge.
- Frame cadence: `tx_done` high at edge M → `tx_send=0` after M. `uart_tx` drops `done` after M+1. The FSM is in IDLE after M+2, and the next byte's `tx_send` rises after M+3 if the FIFO is not empty.
- Inter-frame gap: 3 cycles of `tx_send` low, out of roughly 8690 cycles per frame.
- Stuck `tx_done`: if `tx_done` stays high, the FSM waits in RELEASE indefinitely. No timeout.

## Configuration
- `UART_TXBUF_OVF_EN` defined:
  - `overflow` is a sticky register, set on any rejected push.
  - It is cleared only by `rst`.
- `UART_TXBUF_OVF_EN` undefined:
  - `overflow` is tied to 0 and the sticky register is not built.
  - Pushes while full are still dropped silently.

## Structure
- Shared package `uart_pkg`:
  - FSM state encodings for IDLE, SEND and RELEASE.
  - Byte width constant (8).
  - Bit timer maximum constant shared with the serializer.
- One sub-module: `uart_tx_fifo`. It is a parameterised synchronous FIFO exposing push, pop, head data, `count`, `full` and `empty`.
- The FSM and the holding register live in `uart_tx_buffer`.

## Test plan
- Single byte: push 8'hA5 into an idle buffer.
  - `tx_send` rises 2 cycles later with `tx_data=8'hA5`.
  - The serial line carries start bit, 1,0,1,0,0,1,0,1 (LSB first), then the stop bit.
  - `busy` falls after `done` drops.
- Ordering: push 8'h01..8'h05 back-to-back.
  - Five frames go out in order.
  - Each `tx_send` rise is exactly 3 cycles after the previous `tx_done` rise.
  - `count` reaches 0.
- Fill/overflow with the macro defined:
  - Push 17 bytes while the FSM holds the first byte in SEND, so 1 byte is popped and 16 are queued.
  - `full=1` and the 18th push is dropped.
  - `overflow=1` until `rst`.
  - Without the macro, `overflow` stays 0.
- Wrap-around: stream 40 bytes (0x00..0x27), pacing pushes to keep `count` at or below 16.
  - All 40 bytes transmit in order.
  - The pointers wrap at least twice.
- Reset mid-frame: assert `rst` for 1 cycle during the 4th data bit of the frame with 3 bytes still queued.
  - On the next edge: `tx_send=0`, `count=0`, the `txd` idle level is 1.
  - No further frames are sent.
- Simultaneous push/pop: push exactly on the IDLE→SEND pop edge with `count=2`.
  - `count` stays 2.
  - The head byte is popped correctly.
